// File: rtl/wb_conbus_rr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_conbus_rr : NM-master / NS-slave shared Wishbone bus, round-robin grant
// Revision     : 1.0
// ----------------------------------------------------------------------------
module wb_conbus_rr #(
    parameter int                     NM       = 2,
    parameter int                     NS       = 9,
    parameter int                     S_ADDR_W = 4,
    parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = {4'h9, 4'h8, 4'h7, 4'h6, 4'h5,
                                                  4'h4, 4'h3, 4'h2, 4'h0},
    parameter int                     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic [NM-1:0]    grant_o,
    output logic             busy_o
);

    localparam int OW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [CW-1:0] tcnt_q, tcnt_d, tcnt_inc;
    logic          to_flag_q, to_flag_d;

    logic [31:0] w_madr [NM];
    logic [31:0] w_mdat [NM];
    logic [3:0]  w_msel [NM];
    logic [31:0] w_sdat [NS];

    generate
        for (genvar i = 0; i < NM; i++) begin : g_m_unpack
            assign w_madr[i] = m_adr_i[32*i +: 32];
            assign w_mdat[i] = m_dat_i[32*i +: 32];
            assign w_msel[i] = m_sel_i[4*i +: 4];
        end
        for (genvar k = 0; k < NS; k++) begin : g_s_unpack
            assign w_sdat[k] = s_dat_i[32*k +: 32];
        end
    endgenerate

    logic          w_owned, w_ocyc, w_ostb, w_nomatch, w_ack_sel, w_stall;
    logic [31:0]   w_oadr;
    logic [SW-1:0] w_sel;

    // owner_q keeps the last owner while IDLE, so it doubles as the RR pointer
    assign w_owned = (state_q == ST_OWNED);
    assign w_oadr  = w_madr[owner_q];
    assign w_ocyc  = m_cyc_i[owner_q];
    assign w_ostb  = m_stb_i[owner_q];

    always_comb begin : decode
        w_sel     = '0;
        w_nomatch = 1'b1;
        for (int k = NS - 1; k >= 0; k--) begin
            if (w_oadr[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
                w_sel     = SW'(k);
                w_nomatch = 1'b0;
            end
        end
    end

    assign w_ack_sel = ~w_nomatch & s_ack_i[w_sel];
    assign w_stall   = w_owned & w_ocyc & w_ostb & ~w_nomatch & ~w_ack_sel & ~to_flag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OW'(NM - 1);
            tcnt_q    <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            tcnt_q    <= tcnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    always_comb begin : next_state
        int   cand;
        logic found;
        state_d = state_q;
        owner_d = owner_q;
        found   = 1'b0;
        cand    = 0;
        if (!w_owned || !w_ocyc) begin
            state_d = ST_IDLE;
            for (int i = 1; i <= NM; i++) begin
                cand = int'(owner_q) + i;
                if (cand >= NM) cand = cand - NM;
                if (!found && m_cyc_i[cand]) begin
                    found   = 1'b1;
                    owner_d = OW'(cand);
                    state_d = ST_OWNED;
                end
            end
        end

        tcnt_inc  = (tcnt_q == {CW{1'b1}}) ? tcnt_q : tcnt_q + 1'b1;
        tcnt_d    = '0;
        to_flag_d = 1'b0;
        if (TIMEOUT > 0 && w_stall) begin
            if (tcnt_inc == CW'(TIMEOUT)) to_flag_d = 1'b1;
            else                          tcnt_d    = tcnt_inc;
        end
    end

    always_comb begin : outputs
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = '0;
        s_stb_o = '0;
        grant_o = '0;
        busy_o  = 1'b0;
        if (w_owned) begin
            s_adr_o          = w_oadr;
            s_dat_o          = w_mdat[owner_q];
            s_sel_o          = w_msel[owner_q];
            s_we_o           = m_we_i[owner_q];
            grant_o[owner_q] = 1'b1;
            busy_o           = 1'b1;
            if (!w_nomatch) begin
                s_cyc_o[w_sel]   = w_ocyc;
                s_stb_o[w_sel]   = w_ocyc & w_ostb & ~to_flag_q;
                m_dat_o          = w_sdat[w_sel];
                m_ack_o[owner_q] = w_ack_sel & ~to_flag_q;
            end
            m_err_o[owner_q] = w_ostb & (w_nomatch | to_flag_q);
        end
    end

endmodule
`default_nettype wire
